// File: rtl/cb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cb_pkg
// Purpose  : Shared types and helpers for the cb_nway connection box:
//            select-field width and select-code decoding.
// Revision : 1.0 - initial release
// ============================================================================
package cb_pkg;

  // Classification of a select code against the number of tracks
  typedef enum logic [1:0] {
    SEL_TRACK  = 2'd0,
    SEL_CONST0 = 2'd1,
    SEL_CONST1 = 2'd2,
    SEL_OFF    = 2'd3
  } sel_kind_e;

  // Select field must encode every track plus const0, const1 and "off"
  function automatic int cb_sel_bits(input int ntrk);
    return $clog2(ntrk + 3);
  endfunction

  // Codes below ntrk pick a track, the next two are constants, the rest
  // (including all-ones after reset) disconnect
  function automatic sel_kind_e decode_sel(input logic [31:0] s, input int unsigned ntrk);
    if (s < ntrk)
      return SEL_TRACK;
    else if (s == ntrk)
      return SEL_CONST0;
    else if (s == ntrk + 1)
      return SEL_CONST1;
    else
      return SEL_OFF;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cb_cfg_chain.sv
`default_nettype none
// ============================================================================
// Module   : cb_cfg_chain
// Purpose  : Serial configuration chain with a shadow register, the live
//            (active) word, and the per-track output owner table that is
//            resolved from the shadow word at every commit.
// Revision : 1.0 - initial release
// ============================================================================
module cb_cfg_chain
  import cb_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int NUM_BUS    = 2,
  parameter int NUM_LE     = 2,
  parameter int LE_INPUTS  = 4,
  parameter int LE_OUTPUTS = 1,
  localparam int NTRK      = NUM_BUS * WIDTH,
  localparam int SEL_BITS  = cb_sel_bits(NTRK),
  localparam int LE_CFG    = LE_INPUTS * SEL_BITS + LE_OUTPUTS * (SEL_BITS + 1),
  localparam int CFG_BITS  = NUM_LE * LE_CFG,
  localparam int NOUT      = NUM_LE * LE_OUTPUTS,
  localparam int OWN_BITS  = (NOUT > 1) ? $clog2(NOUT) : 1
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     configEn,
  input  logic                     configCommit,
  input  logic                     configDataIn,
  output logic                     configDataOut,
  output logic [CFG_BITS-1:0]      activeCfg,
  output logic [NTRK*OWN_BITS-1:0] trkOwner,
  output logic [NTRK-1:0]          trkValid,
  output logic                     cfgConflict
);

  logic [CFG_BITS-1:0]      r_sr;
  logic [CFG_BITS-1:0]      r_active;
  logic [NTRK*OWN_BITS-1:0] r_owner;
  logic [NTRK*OWN_BITS-1:0] w_owner;
  logic [NTRK-1:0]          r_ownValid;
  logic [NTRK-1:0]          w_ownValid;
  logic                     r_conflict;
  logic                     w_conflict;

  // Shift chain and commit; commit copies the pre-shift shadow word
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_sr     <= '1;
      r_active <= '1;
    end else begin
      if (configEn)
        r_sr <= {r_sr[CFG_BITS-2:0], configDataIn};
      if (configCommit)
        r_active <= r_sr;
    end
  end

  // Resolve track owners from the shadow word: lowest flat output index wins
  always_comb begin
    logic [SEL_BITS-1:0] s;
    int                  base;
    s          = '0;
    base       = 0;
    w_owner    = '0;
    w_ownValid = '0;
    w_conflict = 1'b0;
    for (int f = 0; f < NOUT; f++) begin
      base = (f / LE_OUTPUTS) * LE_CFG + LE_INPUTS * SEL_BITS + (f % LE_OUTPUTS) * (SEL_BITS + 1);
      s    = r_sr[base +: SEL_BITS];
      if (decode_sel(32'(s), NTRK) == SEL_TRACK) begin
        for (int t = 0; t < NTRK; t++) begin
          if (int'(s) == t) begin
            if (w_ownValid[t]) begin
              w_conflict = 1'b1;
            end else begin
              w_ownValid[t]                    = 1'b1;
              w_owner[t*OWN_BITS +: OWN_BITS] = OWN_BITS'(f);
            end
          end
        end
      end
    end
  end

  // Owner table and collision flag are captured together with the active word
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_owner    <= '0;
      r_ownValid <= '0;
      r_conflict <= 1'b0;
    end else if (configCommit) begin
      r_owner    <= w_owner;
      r_ownValid <= w_ownValid;
      r_conflict <= w_conflict;
    end
  end

  assign configDataOut = r_sr[CFG_BITS-1];
  assign activeCfg     = r_active;
  assign trkOwner      = r_owner;
  assign trkValid      = r_ownValid;
  assign cfgConflict   = r_conflict;

endmodule
`default_nettype wire

// File: rtl/cb_nway.sv
`default_nettype none
// ============================================================================
// Module   : cb_nway
// Purpose  : N-way connection box between NUM_LE logic elements and
//            NUM_BUS buses of WIDTH tracks: LE input muxes, optional output
//            flops and per-track drive with priority collision resolution.
// Revision : 1.0 - initial release
// ============================================================================
module cb_nway
  import cb_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int NUM_BUS    = 2,
  parameter int NUM_LE     = 2,
  parameter int LE_INPUTS  = 4,
  parameter int LE_OUTPUTS = 1,
  localparam int NTRK      = NUM_BUS * WIDTH,
  localparam int NOUT      = NUM_LE * LE_OUTPUTS,
  localparam int NIN       = NUM_LE * LE_INPUTS
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            en,
  input  logic            config_en,
  input  logic            config_commit,
  input  logic            config_data_in,
  output logic            config_data_out,
  output logic            cfg_conflict,
  input  logic [NTRK-1:0] bus_in,
  output logic [NTRK-1:0] bus_out,
  output logic [NTRK-1:0] bus_oe,
  input  logic [NOUT-1:0] le_out,
  output logic [NIN-1:0]  le_in
);

  localparam int SEL_BITS = cb_sel_bits(NTRK);
  localparam int LE_CFG   = LE_INPUTS * SEL_BITS + LE_OUTPUTS * (SEL_BITS + 1);
  localparam int CFG_BITS = NUM_LE * LE_CFG;
  localparam int OWN_BITS = (NOUT > 1) ? $clog2(NOUT) : 1;

  logic [CFG_BITS-1:0]      w_activeCfg;
  logic [NTRK*OWN_BITS-1:0] w_trkOwner;
  logic [NTRK-1:0]          w_trkValid;
  logic [NIN-1:0]           w_leIn;
  logic [SEL_BITS-1:0]      w_outSel [NOUT];
  logic [NOUT-1:0]          w_regMode;
  logic [NOUT-1:0]          r_leOutQ;
  logic [NTRK-1:0]          w_busOut;
  logic [NTRK-1:0]          w_busOe;

  cb_cfg_chain #(
    .WIDTH      (WIDTH),
    .NUM_BUS    (NUM_BUS),
    .NUM_LE     (NUM_LE),
    .LE_INPUTS  (LE_INPUTS),
    .LE_OUTPUTS (LE_OUTPUTS)
  ) u_cfgChain (
    .clk           (clk),
    .nrst          (nrst),
    .configEn      (config_en),
    .configCommit  (config_commit),
    .configDataIn  (config_data_in),
    .configDataOut (config_data_out),
    .activeCfg     (w_activeCfg),
    .trkOwner      (w_trkOwner),
    .trkValid      (w_trkValid),
    .cfgConflict   (cfg_conflict)
  );

  // LE input muxes: track, constant, or 0 when disconnected
  always_comb begin
    logic [SEL_BITS-1:0] s;
    s      = '0;
    w_leIn = '0;
    for (int n = 0; n < NUM_LE; n++) begin
      for (int i = 0; i < LE_INPUTS; i++) begin
        s = w_activeCfg[n*LE_CFG + i*SEL_BITS +: SEL_BITS];
        case (decode_sel(32'(s), NTRK))
          SEL_TRACK: begin
            for (int t = 0; t < NTRK; t++)
              if (int'(s) == t)
                w_leIn[n*LE_INPUTS + i] = bus_in[t];
          end
          SEL_CONST1: w_leIn[n*LE_INPUTS + i] = 1'b1;
          default:    w_leIn[n*LE_INPUTS + i] = 1'b0;
        endcase
      end
    end
  end

  // Unpack output select and registered-mode bit per flat output index
  always_comb begin
    int base;
    base      = 0;
    w_regMode = '0;
    for (int f = 0; f < NOUT; f++) begin
      base         = (f / LE_OUTPUTS) * LE_CFG + LE_INPUTS * SEL_BITS + (f % LE_OUTPUTS) * (SEL_BITS + 1);
      w_outSel[f]  = w_activeCfg[base +: SEL_BITS];
      w_regMode[f] = w_activeCfg[base + SEL_BITS];
    end
  end

  // Output flops capture LE outputs while the fabric is enabled
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)
      r_leOutQ <= '0;
    else if (en)
      r_leOutQ <= le_out;
  end

  // Drive each owned track from its owner; the select cross-check keeps the
  // drive tied to the live word even if the owner table were stale
  always_comb begin
    int own;
    own      = 0;
    w_busOe  = '0;
    w_busOut = '0;
    for (int t = 0; t < NTRK; t++) begin
      own = int'(w_trkOwner[t*OWN_BITS +: OWN_BITS]);
      if (en && w_trkValid[t] && (own < NOUT)) begin
        if (int'(w_outSel[own]) == t) begin
          w_busOe[t]  = 1'b1;
          w_busOut[t] = w_regMode[own] ? r_leOutQ[own] : le_out[own];
        end
      end
    end
  end

  assign le_in   = w_leIn;
  assign bus_oe  = w_busOe;
  assign bus_out = w_busOut;

endmodule
`default_nettype wire
